// File: rtl/seg_scan_pkg.sv
// Shared types and default parameters for the seg_scan display scanner.
package seg_scan_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } slot_st_e;

   localparam int DEF_N_DIGITS  = 4;
   localparam int DEF_SCAN_DIV  = 50000;
   localparam int DEF_BLANK_CYC = 500;

endpackage

// File: rtl/seg_scan_slot_timer.sv
// Per-digit slot timer: counts 0..SCAN_DIV-1, flags the last blank cycle and
// the last cycle of the slot.
module seg_scan_slot_timer
   import seg_scan_pkg::*;
#(
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int BLANK_CYC = DEF_BLANK_CYC
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_slot_end,
   output logic o_blank_end
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   logic [CW-1:0] r_cnt;

   // Slot counter, wraps at the end of each digit slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_slot_end  = (r_cnt == CNT_LAST);
   assign o_blank_end = (r_cnt == BLANK_LAST);

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scan driver for a common-anode N-digit 7-segment display.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_BLANK | first BLANK_CYC cycles of a slot: all digits off, nibble preset
//  ST_SHOW  | rest of the slot: current digit enabled (unless lz-suppressed)
//
// Outputs are registered from the current state, so they trail the slot
// counter by one cycle. New frame data is swapped in only at the frame wrap.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int N_DIGITS  = DEF_N_DIGITS,
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int BLANK_CYC = DEF_BLANK_CYC
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [4*N_DIGITS-1:0] i_value,
   input  logic [N_DIGITS-1:0]   i_dp,
   input  logic                  i_load,
   input  logic                  i_lz_en,
   output logic [3:0]            o_nibble,
   output logic [N_DIGITS-1:0]   o_dig_sel_n,
   output logic                  o_dp_n,
   output logic                  o_frame
);

   localparam int IW = $clog2(N_DIGITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   slot_st_e              r_state;
   slot_st_e              w_state_nxt;
   logic [IW-1:0]         r_idx;
   logic [4*N_DIGITS-1:0] r_disp_val;
   logic [N_DIGITS-1:0]   r_disp_dp;
   logic [4*N_DIGITS-1:0] r_pend_val;
   logic [N_DIGITS-1:0]   r_pend_dp;
   logic                  r_pend_vld;
   logic                  w_slot_end;
   logic                  w_blank_end;
   logic                  w_frame;
   logic                  w_suppress;
   logic [3:0]            w_nibble;
   logic [N_DIGITS-1:0]   w_sel_n;
   logic                  w_dp_n;

   seg_scan_slot_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .o_slot_end  (w_slot_end),
      .o_blank_end (w_blank_end)
   );

   assign w_frame = w_slot_end && (r_idx == IDX_LAST);
   assign o_frame = w_frame;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_BLANK;
      else       r_state <= w_state_nxt;
   end

   // Next state: slot end always returns to BLANK, last blank cycle enters SHOW.
   always_comb begin
      w_state_nxt = r_state;
      if (w_slot_end)       w_state_nxt = ST_BLANK;
      else if (w_blank_end) w_state_nxt = ST_SHOW;
   end

   // Digit index advances once per slot and wraps after the last digit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx <= '0;
      end else if (w_slot_end) begin
         if (r_idx == IDX_LAST) r_idx <= '0;
         else                   r_idx <= r_idx + IW'(1);
      end
   end

   // Pending/display buffers; a load coinciding with the wrap bypasses pending.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_disp_val <= '0;
         r_disp_dp  <= '0;
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_pend_vld <= 1'b0;
      end else if (w_frame && i_load) begin
         r_disp_val <= i_value;
         r_disp_dp  <= i_dp;
         r_pend_vld <= 1'b0;
      end else if (w_frame && r_pend_vld) begin
         r_disp_val <= r_pend_val;
         r_disp_dp  <= r_pend_dp;
         r_pend_vld <= 1'b0;
      end else if (i_load) begin
         r_pend_val <= i_value;
         r_pend_dp  <= i_dp;
         r_pend_vld <= 1'b1;
      end
   end

   // Leading-zero suppression: current digit and all digits above it are zero.
   always_comb begin
      logic w_rest_zero;
      w_rest_zero = 1'b1;
      w_suppress  = 1'b0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         w_rest_zero = w_rest_zero && (r_disp_val[4*k +: 4] == 4'h0);
         if (r_idx == IW'(k)) w_suppress = w_rest_zero;
      end
      w_suppress = w_suppress && i_lz_en;
   end

   // Output decode; a suppressed digit also keeps its decimal point dark.
   always_comb begin
      w_nibble = 4'h0;
      w_sel_n  = '1;
      w_dp_n   = 1'b1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nibble = r_disp_val[4*k +: 4];
            if (r_state == ST_SHOW && !w_suppress) begin
               w_sel_n[k] = 1'b0;
               w_dp_n     = ~r_disp_dp[k];
            end
         end
      end
   end

   // Output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_nibble    <= 4'h0;
         o_dig_sel_n <= '1;
         o_dp_n      <= 1'b1;
      end else begin
         o_nibble    <= w_nibble;
         o_dig_sel_n <= w_sel_n;
         o_dp_n      <= w_dp_n;
      end
   end

endmodule
